// File: rtl/sram_array_pkg.sv
// Shared constants and types for the ganged SRAM array.
// Ports: none (package). Provides macro geometry, the RW-port owner enum
// and the byte-lane merge helper used by macro writes and read forwarding.
package sram_array_pkg;

  localparam int ROW_DEPTH = 512;  // words per macro
  localparam int ROW_W     = 9;    // row index width
  localparam int MACRO_W   = 32;   // bits per macro word

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_MGMT = 1'b1
  } owner_e;

  // Byte-wise merge: bytes with mask set come from new_w, others from old_w.
  function automatic logic [MACRO_W-1:0] byte_merge(input logic [MACRO_W-1:0] old_w,
                                                    input logic [MACRO_W-1:0] new_w,
                                                    input logic [3:0]         mask);
    logic [MACRO_W-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_lane_bank.sv
// One depth row of LANES dual-port 32-bit macros (port 0 RW, port 1 R).
// Ports: active-high rw_en/rw_we/rd_en are turned into active-low csb/web
// at the macro pins; row, write data, byte mask in; registered read data out.
module sram_lane_bank
  import sram_array_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                       clk,
  input  logic                       rw_en,
  input  logic                       rw_we,
  input  logic [ROW_W-1:0]           rw_row,
  input  logic [MACRO_W*LANES-1:0]   rw_wdata,
  input  logic [4*LANES-1:0]         rw_wmask,
  output logic [MACRO_W*LANES-1:0]   rw_rdata,
  input  logic                       rd_en,
  input  logic [ROW_W-1:0]           rd_row,
  output logic [MACRO_W*LANES-1:0]   rd_rdata
);

  logic csb0, web0, csb1;

  assign csb0 = ~rw_en;
  assign web0 = ~rw_we;
  assign csb1 = ~rd_en;

  // Behavioural macro: output register only updates on a read, so dout
  // holds its last read value across idle and write cycles. A port-1 read
  // of a row being written on port 0 returns the old contents.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [MACRO_W-1:0] mem [ROW_DEPTH];
    logic [MACRO_W-1:0] dout0_q;
    logic [MACRO_W-1:0] dout1_q;

    always_ff @(posedge clk) begin
      if (!csb0) begin
        if (!web0) begin
          mem[rw_row] <= byte_merge(mem[rw_row], rw_wdata[MACRO_W*l +: MACRO_W],
                                    rw_wmask[4*l +: 4]);
        end else begin
          dout0_q <= mem[rw_row];
        end
      end
      if (!csb1) dout1_q <= mem[rd_row];
    end

    assign rw_rdata[MACRO_W*l +: MACRO_W] = dout0_q;
    assign rd_rdata[MACRO_W*l +: MACRO_W] = dout1_q;
  end

endmodule

// File: rtl/sram_array.sv
// Banked, lane-ganged SRAM with an arbitrated RW port (core/mgmt) and a read-only port.
// Ports: wb_clk_i/wb_rst_ni; c_* and m_* RW requestors; r_* read requestor.
// Build option SRAM_FWD_EN: forward write data to a same-address read instead of stalling it.
module sram_array
  import sram_array_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int BANKS      = 2,
  parameter int STARVE_LIM = 4,
  localparam int DW = MACRO_W * LANES,
  localparam int MW = 4 * LANES,
  localparam int AW = ROW_W + $clog2(BANKS)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [MW-1:0] c_wmask,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  input  logic [MW-1:0] m_wmask,
  output logic          m_gnt,
  output logic          m_rvalid,
  output logic [DW-1:0] m_rdata,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  output logic          r_rvalid,
  output logic [DW-1:0] r_rdata
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  owner_e        owner;
  logic          rw_en, rw_we, collision;
  logic [AW-1:0] rw_addr;
  logic [DW-1:0] rw_wdata;
  logic [MW-1:0] rw_wmask;
  logic [BW-1:0] rw_bank, r_bank;
  logic [BANKS-1:0] bank_rw_en, bank_rd_en;
  logic [DW-1:0] bank_rw_rdata [BANKS];
  logic [DW-1:0] bank_rd_rdata [BANKS];
  logic [DW-1:0] rw_fresh, r_fresh;

  logic [SW-1:0] starve_d, starve_q;
  logic          c_rvalid_d, c_rvalid_q, m_rvalid_d, m_rvalid_q, r_rvalid_d, r_rvalid_q;
  logic [BW-1:0] rw_bank_d, rw_bank_q, r_bank_d, r_bank_q;
  logic [DW-1:0] c_hold_d, c_hold_q, m_hold_d, m_hold_q, r_hold_d, r_hold_q;
`ifdef SRAM_FWD_EN
  logic          fwd_d, fwd_q;
  logic [DW-1:0] fwd_wdata_d, fwd_wdata_q;
  logic [MW-1:0] fwd_wmask_d, fwd_wmask_q;
`endif

  // Arbitration: core wins unless mgmt is alone or has been denied STARVE_LIM times.
  always_comb begin
    owner = (m_req && (!c_req || starve_q == SW'(STARVE_LIM))) ? OWN_MGMT : OWN_CORE;
    c_gnt = wb_rst_ni && c_req && (owner == OWN_CORE);
    m_gnt = wb_rst_ni && m_req && (owner == OWN_MGMT);
    rw_en    = c_gnt || m_gnt;
    rw_we    = (owner == OWN_MGMT) ? m_we    : c_we;
    rw_addr  = (owner == OWN_MGMT) ? m_addr  : c_addr;
    rw_wdata = (owner == OWN_MGMT) ? m_wdata : c_wdata;
    rw_wmask = (owner == OWN_MGMT) ? m_wmask : c_wmask;
    collision = r_req && rw_en && rw_we && (r_addr == rw_addr);
`ifdef SRAM_FWD_EN
    r_gnt = wb_rst_ni && r_req;
`else
    r_gnt = wb_rst_ni && r_req && !collision;
`endif
  end

  if (BANKS > 1) begin : g_bidx
    assign rw_bank = rw_addr[AW-1:ROW_W];
    assign r_bank  = r_addr[AW-1:ROW_W];
  end else begin : g_bidx1
    assign rw_bank = '0;
    assign r_bank  = '0;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_rw_en[b] = rw_en && (rw_bank == BW'(b));
    assign bank_rd_en[b] = r_gnt && (r_bank == BW'(b));

    sram_lane_bank #(.LANES(LANES)) u_bank (
      .clk      (wb_clk_i),
      .rw_en    (bank_rw_en[b]),
      .rw_we    (rw_we),
      .rw_row   (rw_addr[ROW_W-1:0]),
      .rw_wdata (rw_wdata),
      .rw_wmask (rw_wmask),
      .rw_rdata (bank_rw_rdata[b]),
      .rd_en    (bank_rd_en[b]),
      .rd_row   (r_addr[ROW_W-1:0]),
      .rd_rdata (bank_rd_rdata[b])
    );
  end

  always_comb begin
    starve_d = starve_q;
    if (!m_req || m_gnt)                              starve_d = '0;
    else if (c_gnt && starve_q != SW'(STARVE_LIM))    starve_d = starve_q + 1'b1;

    c_rvalid_d = c_gnt && !c_we;
    m_rvalid_d = m_gnt && !m_we;
    r_rvalid_d = r_gnt;
    rw_bank_d  = (rw_en && !rw_we) ? rw_bank : rw_bank_q;
    r_bank_d   = r_gnt ? r_bank : r_bank_q;

    rw_fresh = bank_rw_rdata[rw_bank_q];
    r_fresh  = bank_rd_rdata[r_bank_q];
`ifdef SRAM_FWD_EN
    fwd_d       = r_gnt && collision;
    fwd_wdata_d = collision ? rw_wdata : fwd_wdata_q;
    fwd_wmask_d = collision ? rw_wmask : fwd_wmask_q;
    // Macro returned pre-write contents; overlay the bytes that were written.
    if (fwd_q) begin
      for (int i = 0; i < MW; i++) begin
        if (fwd_wmask_q[i]) r_fresh[8*i +: 8] = fwd_wdata_q[8*i +: 8];
      end
    end
`endif

    // The shared RW macro output is reused by both requestors, so each
    // side keeps its own copy of its last read.
    c_rdata  = c_rvalid_q ? rw_fresh : c_hold_q;
    m_rdata  = m_rvalid_q ? rw_fresh : m_hold_q;
    r_rdata  = r_rvalid_q ? r_fresh  : r_hold_q;
    c_hold_d = c_rdata;
    m_hold_d = m_rdata;
    r_hold_d = r_rdata;

    c_rvalid = c_rvalid_q;
    m_rvalid = m_rvalid_q;
    r_rvalid = r_rvalid_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      m_rvalid_q <= 1'b0;
      r_rvalid_q <= 1'b0;
      rw_bank_q  <= '0;
      r_bank_q   <= '0;
`ifdef SRAM_FWD_EN
      fwd_q      <= 1'b0;
`endif
    end else begin
      starve_q   <= starve_d;
      c_rvalid_q <= c_rvalid_d;
      m_rvalid_q <= m_rvalid_d;
      r_rvalid_q <= r_rvalid_d;
      rw_bank_q  <= rw_bank_d;
      r_bank_q   <= r_bank_d;
`ifdef SRAM_FWD_EN
      fwd_q      <= fwd_d;
`endif
    end
  end

  // Datapath holding registers: contents are don't-care after reset.
  always_ff @(posedge wb_clk_i) begin
    c_hold_q <= c_hold_d;
    m_hold_q <= m_hold_d;
    r_hold_q <= r_hold_d;
`ifdef SRAM_FWD_EN
    fwd_wdata_q <= fwd_wdata_d;
    fwd_wmask_q <= fwd_wmask_d;
`endif
  end

endmodule
